fu_s_sched: RTL and testbench
=============================

// Module: fu_s_sched
// PURPOSE
//  Scoreboard issue scheduler for the scalar functional units (ALU, LD/ST, BRANCH).
//  - Accepts one dispatch per cycle and tracks each FU through a per-FU FSM.
//  - Waits on producer tags t1/t2, pulses issue to the FU, then arbitrates the shared writeback bus.
//  - Sits between decode/dispatch and the scalar FU status table; its busy/tag state mirrors the table.
// PARAMETERS
//  NUM_FU  3  number of scalar FUs (index 0=ALU, 1=LDST, 2=BRANCH)
//  FU_W    2  width of an FU index, >= clog2(NUM_FU)
//  REG_W   5  destination register index width
// PORTS
//  CLK          in   1            clock
//  RST          in   1            async active-high reset
//  flush        in   1            squash all in-flight FU state
//  disp_valid   in   1            dispatch request
//  disp_ready   out  1            dispatch accepted when valid&&ready
//  disp_fu      in   FU_W         target FU
//  disp_rd      in   REG_W        destination reg (0 = none)
//  disp_t1      in   FU_W+1       {pending, producer FU} for src1
//  disp_t2      in   FU_W+1       {pending, producer FU} for src2
//  fu_issue     out  NUM_FU       one-cycle start pulse per FU
//  fu_done      in   NUM_FU       FU result ready (level, held until writeback)
//  busy         out  NUM_FU       FU state != IDLE
//  wb_valid     out  1            writeback grant this cycle
//  wb_fu        out  FU_W         granted FU
//  wb_rd        out  REG_W        granted FU's destination
//  perf_issue   out  32           issue counter (see CONFIGURATION)
//  perf_stall   out  32           dispatch-stall counter
// BEHAVIOUR
//  - Reset, async on RST high:
//    - all FSMs IDLE; tags and rd cleared; RR pointer 0.
//    - busy=0, fu_issue=0, wb_valid=0, wb_fu=0, wb_rd=0, perf_*=0.
//    - disp_ready=1 after reset, provided flush=0.
//  - Per-FU FSM: IDLE -> (WAIT | ISSUE) -> EXEC -> WB -> IDLE.
//    - IDLE: on accept, latch rd and tags.
//      - Go to ISSUE if both tags are clear after bypass; otherwise go to WAIT.
//    - WAIT: go to ISSUE in the cycle both tags become clear.
//    - ISSUE: exactly 1 cycle with fu_issue[k]=1, then EXEC.
//    - EXEC: go to WB when fu_done[k]=1. fu_done is ignored outside EXEC and WB.
//    - WB: request the bus; on grant, go to IDLE next cycle.
//  - Timing:
//    - Minimum latency: accept at cycle N -> fu_issue at N+1.
//    - done at M -> wb_valid at M+1 earliest.
//  - disp_ready = !flush && FSM[disp_fu]==IDLE && no WAW hazard.
//    - WAW hazard: disp_rd!=0 and disp_rd equals the rd of any busy FU.
//  - disp_fu >= NUM_FU: disp_ready=0.
//  - Writeback arbiter:
//    - Round-robin among FUs in WB, starting at the RR pointer.
//    - After a grant, RR = granted+1, wrapping NUM_FU-1 -> 0.
//    - Pointer holds when nothing is granted.
//    - wb_* are combinational from current state; at most one grant per cycle.
//  - Tag clear:
//    - A grant to FU j clears the pending bit of every stored t1/t2 naming j in the same cycle.
//    - Bypass: a dispatch tag naming j is treated as clear when j is granted in the accept cycle.
//  - A stored or dispatched tag naming an IDLE FU is treated as clear (stale producer).
//  - Same-cycle events:
//    - An FU granted in cycle N is IDLE at N+1, so it can accept at N+1, not at N.
//    - flush has priority over dispatch, grant and done. In the flush cycle wb_valid=0.
//  - After flush, at the next edge:
//    - all FSMs IDLE; tags and rd cleared.
//    - RR pointer keeps its value; perf counters keep their values.
//  - RST asserted mid-operation: immediate return to reset state; pulses are not completed.
// CONFIGURATION
//  - FU_S_SCHED_PERF_EN defined:
//    - perf_issue += 1 per cycle with any fu_issue bit set.
//    - perf_stall += 1 per cycle with disp_valid && !disp_ready.
//    - Both counters saturate at 32'hFFFF_FFFF.
//  - FU_S_SCHED_PERF_EN undefined: counters are not built; perf_issue = perf_stall = 0 constant.
// TESTING
//  - Ready path: after RST, dispatch fu=0, rd=3, t1=t2=0 at N -> fu_issue=3'b001 at N+1.
//    - Then done=1 at N+3 -> wb_valid=1, wb_fu=0, wb_rd=3 at N+4; busy[0]=0 at N+5.
//  - Dependency: ALU rd=5 in flight; dispatch fu=1 with t1={1,0}.
//    - FU1 stays in WAIT until ALU's wb cycle, then fu_issue=3'b010 on the next cycle.
//    - Also cover the bypass case: same-cycle grant plus dispatch naming FU0 -> ISSUE directly.
//  - Arbitration: FU0, FU1, FU2 all in WB with RR=0 -> grants 0, 1, 2 on consecutive cycles.
//    - RR ends at 0.
//    - FU1 re-enters WB while RR=2 -> FU2 is granted before FU1.
//  - Hazards: busy ALU rd=7; dispatch fu=2 rd=7 -> disp_ready=0.
//    - rd=0 to an idle FU -> disp_ready=1.
//    - disp_fu=3 -> disp_ready=0.
//  - Flush in cycle N with FUs in WAIT, EXEC and WB plus a valid dispatch -> no accept, wb_valid=0.
//    - At N+1: busy=0, disp_ready=1.
//    - Repeat with RST pulsed mid-EXEC.
//  - With FU_S_SCHED_PERF_EN: 4 stalled cycles plus 2 issues -> perf_stall=4, perf_issue=2.
//    - Without the macro: both counters read 0.

Source files
------------

// File: rtl/fu_s_sched.sv
// fu_s_sched: scoreboard issue scheduler for the scalar FUs (0=ALU, 1=LDST, 2=BRANCH).
// Define FU_S_SCHED_PERF_EN to build the saturating issue/stall performance counters.
module fu_s_sched #(
  parameter int NUM_FU = 3,
  parameter int FU_W   = 2,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [FU_W-1:0]   disp_fu,
  input  logic [REG_W-1:0]  disp_rd,
  input  logic [FU_W:0]     disp_t1,
  input  logic [FU_W:0]     disp_t2,
  output logic [NUM_FU-1:0] fu_issue,
  input  logic [NUM_FU-1:0] fu_done,
  output logic [NUM_FU-1:0] busy,
  output logic              wb_valid,
  output logic [FU_W-1:0]   wb_fu,
  output logic [REG_W-1:0]  wb_rd,
  output logic [31:0]       perf_issue,
  output logic [31:0]       perf_stall
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_EXEC, S_WB} fu_state_t;

  logic [NUM_FU-1:0]            wb_req;
  logic [NUM_FU-1:0]            grant;
  logic [NUM_FU-1:0][REG_W-1:0] rd_all;
  logic [FU_W-1:0]              rr_reg;
  logic                         accept;
  logic                         fu_free;
  logic                         waw;
  logic [FU_W:0]                scan_idx;
  logic [FU_W-1:0]              pick;
  logic                         found;

  // A tag blocks only while pending, naming a busy producer that is not being granted now.
  function automatic logic tag_live(input logic [FU_W:0] tag,
                                    input logic [NUM_FU-1:0] busy_v,
                                    input logic [NUM_FU-1:0] gnt);
    logic live;
    live = 1'b0;
    for (int j = 0; j < NUM_FU; j++) begin
      if (tag[FU_W] && tag[FU_W-1:0] == FU_W'(j) && busy_v[j] && !gnt[j])
        live = 1'b1;
    end
    return live;
  endfunction

  always_comb begin
    fu_free = 1'b0;
    waw     = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (disp_fu == FU_W'(k) && !busy[k])
        fu_free = 1'b1;
      if (disp_rd != '0 && busy[k] && rd_all[k] == disp_rd)
        waw = 1'b1;
    end
    disp_ready = !flush && fu_free && !waw;
  end

  assign accept = disp_valid && disp_ready;

  // Round-robin scan starting at the pointer; flush blanks the bus for the cycle.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      scan_idx = {1'b0, rr_reg} + (FU_W+1)'(i);
      if (scan_idx >= (FU_W+1)'(NUM_FU))
        scan_idx = scan_idx - (FU_W+1)'(NUM_FU);
      if (!found && !flush && wb_req[scan_idx[FU_W-1:0]]) begin
        found = 1'b1;
        pick  = scan_idx[FU_W-1:0];
      end
    end
    if (found)
      grant[pick] = 1'b1;
  end

  assign wb_valid = found;
  assign wb_fu    = pick;
  assign wb_rd    = found ? rd_all[pick] : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      rr_reg <= '0;
    else if (found)
      rr_reg <= (pick == FU_W'(NUM_FU-1)) ? '0 : pick + 1'b1;
  end

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    fu_state_t        state_reg;
    logic [REG_W-1:0] rd_reg;
    logic [FU_W:0]    t1_reg;
    logic [FU_W:0]    t2_reg;
    logic             sel;
    logic             t1_live_d;
    logic             t2_live_d;
    logic             t1_live_s;
    logic             t2_live_s;

    assign sel       = accept && (disp_fu == FU_W'(gi));
    assign t1_live_d = tag_live(disp_t1, busy, grant);
    assign t2_live_d = tag_live(disp_t2, busy, grant);
    assign t1_live_s = tag_live(t1_reg, busy, grant);
    assign t2_live_s = tag_live(t2_reg, busy, grant);

    assign busy[gi]     = (state_reg != S_IDLE);
    assign fu_issue[gi] = (state_reg == S_ISSUE);
    assign wb_req[gi]   = (state_reg == S_WB);
    assign rd_all[gi]   = rd_reg;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_reg <= S_IDLE;
        rd_reg    <= '0;
        t1_reg    <= '0;
        t2_reg    <= '0;
      end else if (flush) begin
        state_reg <= S_IDLE;
        rd_reg    <= '0;
        t1_reg    <= '0;
        t2_reg    <= '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (sel) begin
              rd_reg    <= disp_rd;
              t1_reg    <= {t1_live_d, disp_t1[FU_W-1:0]};
              t2_reg    <= {t2_live_d, disp_t2[FU_W-1:0]};
              state_reg <= (t1_live_d || t2_live_d) ? S_WAIT : S_ISSUE;
            end
          end
          S_WAIT: begin
            t1_reg <= {t1_live_s, t1_reg[FU_W-1:0]};
            t2_reg <= {t2_live_s, t2_reg[FU_W-1:0]};
            if (!t1_live_s && !t2_live_s)
              state_reg <= S_ISSUE;
          end
          S_ISSUE: state_reg <= S_EXEC;
          S_EXEC: begin
            if (fu_done[gi])
              state_reg <= S_WB;
          end
          S_WB: begin
            if (grant[gi])
              state_reg <= S_IDLE;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

`ifdef FU_S_SCHED_PERF_EN
  logic [31:0] perf_issue_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_issue_reg <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (|fu_issue && perf_issue_reg != 32'hFFFF_FFFF)
        perf_issue_reg <= perf_issue_reg + 32'd1;
      if (disp_valid && !disp_ready && perf_stall_reg != 32'hFFFF_FFFF)
        perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_issue = perf_issue_reg;
  assign perf_stall = perf_stall_reg;
`else
  assign perf_issue = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_fu_s_sched.sv
// Self-checking bench for fu_s_sched: directed scenarios plus a randomized run
// compared against a flag-based behavioural scoreboard of each FU's progress.
module tb_fu_s_sched;
  logic        CLK;
  logic        RST;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [1:0]  disp_fu;
  logic [4:0]  disp_rd;
  logic [2:0]  disp_t1;
  logic [2:0]  disp_t2;
  logic [2:0]  fu_issue;
  logic [2:0]  fu_done;
  logic [2:0]  busy;
  logic        wb_valid;
  logic [1:0]  wb_fu;
  logic [4:0]  wb_rd;
  logic [31:0] perf_issue;
  logic [31:0] perf_stall;

  int vectors;
  int miscompares;

  fu_s_sched #(.NUM_FU(3), .FU_W(2), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_fu(disp_fu), .disp_rd(disp_rd), .disp_t1(disp_t1), .disp_t2(disp_t2),
    .fu_issue(fu_issue), .fu_done(fu_done), .busy(busy),
    .wb_valid(wb_valid), .wb_fu(wb_fu), .wb_rd(wb_rd),
    .perf_issue(perf_issue), .perf_stall(perf_stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; disp_valid = 1'b0; disp_fu = '0; disp_rd = '0;
    disp_t1 = '0; disp_t2 = '0; fu_done = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic send(input int fu, input int rd, input logic [2:0] t1, input logic [2:0] t2);
    disp_valid = 1'b1; disp_fu = 2'(fu); disp_rd = 5'(rd); disp_t1 = t1; disp_t2 = t2;
    step();
    disp_valid = 1'b0;
  endtask

  // Brings every FU in mask through issue and exec so all reach writeback together.
  task automatic all_to_wb(input logic [2:0] mask);
    for (int k = 0; k < 3; k++)
      if (mask[k]) send(k, 10 + k, 3'b000, 3'b000);
    repeat (2) step();
    fu_done = mask;
    step();
    fu_done = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    step();
    #2;
    vectors++;
    if ({busy, fu_issue, wb_valid, wb_fu, wb_rd} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b issue=%b wbv=%b wbfu=%0d wbrd=%0d, expected all 0",
               busy, fu_issue, wb_valid, wb_fu, wb_rd);
    end
    vectors++;
    if (perf_issue !== 32'd0 || perf_stall !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_perf: got issue=%0d stall=%0d, expected 0 0", perf_issue, perf_stall);
    end
    step();
    RST = 1'b0;
    @(negedge CLK);
    vectors++;
    if (disp_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 1", disp_ready);
    end
    flush = 1'b1;
    #1;
    vectors++;
    if (disp_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: got %b expected 0", disp_ready);
    end
    flush = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_ready_path();
    do_reset();
    disp_valid = 1'b1; disp_fu = 2'd0; disp_rd = 5'd3; disp_t1 = '0; disp_t2 = '0;
    @(negedge CLK);
    vectors++;
    if (disp_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_accept: got %b expected 1", disp_ready);
    end
    step();
    disp_valid = 1'b0;
    @(negedge CLK);
    vectors++;
    if (fu_issue !== 3'b001) begin
      miscompares++;
      $display("FAIL ready_issue: got %b expected 001", fu_issue);
    end
    step();
    @(negedge CLK);
    vectors++;
    if (fu_issue !== 3'b000 || busy !== 3'b001) begin
      miscompares++;
      $display("FAIL ready_exec: got issue=%b busy=%b expected 000 001", fu_issue, busy);
    end
    step();
    fu_done = 3'b001;
    @(negedge CLK);
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_no_early_wb: got %b expected 0", wb_valid);
    end
    step();
    @(negedge CLK);
    vectors++;
    if ({wb_valid, wb_fu, wb_rd} !== {1'b1, 2'd0, 5'd3}) begin
      miscompares++;
      $display("FAIL ready_wb: got v=%b fu=%0d rd=%0d expected 1 0 3", wb_valid, wb_fu, wb_rd);
    end
    step();
    fu_done = 3'b000;
    @(negedge CLK);
    vectors++;
    if (busy !== 3'b000) begin
      miscompares++;
      $display("FAIL ready_idle: got busy=%b expected 000", busy);
    end
    $display("test_ready_path done");
  endtask

  task automatic test_dependency();
    do_reset();
    send(0, 5, 3'b000, 3'b000);
    send(1, 6, 3'b100, 3'b000);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      vectors++;
      if (fu_issue !== 3'b000 || busy !== 3'b011) begin
        miscompares++;
        $display("FAIL dep_wait%0d: got issue=%b busy=%b expected 000 011", c, fu_issue, busy);
      end
      step();
    end
    fu_done = 3'b001;
    step();
    @(negedge CLK);
    vectors++;
    if ({wb_valid, wb_fu, fu_issue} !== {1'b1, 2'd0, 3'b000}) begin
      miscompares++;
      $display("FAIL dep_wb: got v=%b fu=%0d issue=%b expected 1 0 000", wb_valid, wb_fu, fu_issue);
    end
    step();
    fu_done = 3'b000;
    @(negedge CLK);
    vectors++;
    if (fu_issue !== 3'b010) begin
      miscompares++;
      $display("FAIL dep_issue: got %b expected 010", fu_issue);
    end
    $display("test_dependency done");
  endtask

  task automatic test_bypass();
    do_reset();
    send(0, 5, 3'b000, 3'b000);
    step();
    fu_done = 3'b001;
    step();
    fu_done = 3'b000;
    disp_valid = 1'b1; disp_fu = 2'd2; disp_rd = 5'd9; disp_t1 = 3'b100; disp_t2 = 3'b000;
    @(negedge CLK);
    vectors++;
    if (wb_valid !== 1'b1 || disp_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_setup: got wbv=%b ready=%b expected 1 1", wb_valid, disp_ready);
    end
    step();
    disp_valid = 1'b0;
    @(negedge CLK);
    vectors++;
    if (fu_issue !== 3'b100) begin
      miscompares++;
      $display("FAIL bypass_issue: got %b expected 100", fu_issue);
    end
    $display("test_bypass done");
  endtask

  task automatic test_arbitration();
    int seq [9];
    seq = '{0, 1, 2, -1, 0, 2, 1, 2, 1};
    do_reset();
    for (int p = 0; p < 9; p++) begin
      if (p == 0) all_to_wb(3'b111);
      if (p == 4) all_to_wb(3'b101);
      if (p == 6) all_to_wb(3'b010);
      if (p == 7) all_to_wb(3'b110);
      @(negedge CLK);
      vectors++;
      if (seq[p] < 0) begin
        if (wb_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL arb_idle: got wbv=%b expected 0", wb_valid);
        end
      end else if (wb_valid !== 1'b1 || wb_fu !== 2'(seq[p]) || wb_rd !== 5'(10 + seq[p])) begin
        miscompares++;
        $display("FAIL arb_grant%0d: got v=%b fu=%0d rd=%0d expected 1 %0d %0d",
                 p, wb_valid, wb_fu, wb_rd, seq[p], 10 + seq[p]);
      end
      step();
    end
    $display("test_arbitration done");
  endtask

  task automatic test_hazards();
    do_reset();
    send(0, 7, 3'b000, 3'b000);
    disp_valid = 1'b1;
    for (int h = 0; h < 5; h++) begin
      logic exp;
      case (h)
        0: begin disp_fu = 2'd2; disp_rd = 5'd7; exp = 1'b0; end
        1: begin disp_fu = 2'd2; disp_rd = 5'd0; exp = 1'b1; end
        2: begin disp_fu = 2'd3; disp_rd = 5'd1; exp = 1'b0; end
        3: begin disp_fu = 2'd0; disp_rd = 5'd8; exp = 1'b0; end
        default: begin disp_fu = 2'd1; disp_rd = 5'd8; exp = 1'b1; end
      endcase
      #1;
      vectors++;
      if (disp_ready !== exp) begin
        miscompares++;
        $display("FAIL hazard%0d: fu=%0d rd=%0d got ready=%b expected %b", h, disp_fu, disp_rd, disp_ready, exp);
      end
    end
    disp_valid = 1'b0;
    $display("test_hazards done");
  endtask

  task automatic test_flush();
    do_reset();
    send(0, 1, 3'b000, 3'b000);
    send(1, 2, 3'b000, 3'b000);
    fu_done = 3'b001;
    send(2, 3, 3'b101, 3'b000);
    fu_done = 3'b000;
    flush = 1'b1;
    disp_valid = 1'b1; disp_fu = 2'd0; disp_rd = 5'd4;
    @(negedge CLK);
    vectors++;
    if (busy !== 3'b111 || wb_valid !== 1'b0 || disp_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_cycle: got busy=%b wbv=%b ready=%b expected 111 0 0", busy, wb_valid, disp_ready);
    end
    step();
    flush = 1'b0;
    @(negedge CLK);
    vectors++;
    if (busy !== 3'b000 || disp_ready !== 1'b1 || fu_issue !== 3'b000) begin
      miscompares++;
      $display("FAIL flush_after: got busy=%b ready=%b issue=%b expected 000 1 000", busy, disp_ready, fu_issue);
    end
    disp_valid = 1'b0;
    $display("test_flush done");
  endtask

  task automatic test_rst_mid();
    do_reset();
    send(0, 4, 3'b000, 3'b000);
    step();
    fu_done = 3'b001;
    #2;
    RST = 1'b1;
    #1;
    vectors++;
    if (busy !== 3'b000 || fu_issue !== 3'b000 || wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: got busy=%b issue=%b wbv=%b expected 000 000 0", busy, fu_issue, wb_valid);
    end
    step();
    RST = 1'b0;
    fu_done = 3'b000;
    @(negedge CLK);
    vectors++;
    if (disp_ready !== 1'b1 || busy !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_mid_ready: got ready=%b busy=%b expected 1 000", disp_ready, busy);
    end
    send(0, 4, 3'b000, 3'b000);
    @(negedge CLK);
    vectors++;
    if (fu_issue !== 3'b001) begin
      miscompares++;
      $display("FAIL rst_mid_reissue: got %b expected 001", fu_issue);
    end
    $display("test_rst_mid done");
  endtask

  task automatic test_perf();
    int exp_i;
    int exp_s;
`ifdef FU_S_SCHED_PERF_EN
    exp_i = 2; exp_s = 4;
`else
    exp_i = 0; exp_s = 0;
`endif
    do_reset();
    disp_valid = 1'b1; disp_fu = 2'd3; disp_rd = 5'd1;
    repeat (4) step();
    disp_valid = 1'b0;
    send(0, 1, 3'b000, 3'b000);
    send(1, 2, 3'b000, 3'b000);
    step();
    @(negedge CLK);
    vectors++;
    if (perf_issue !== 32'(exp_i) || perf_stall !== 32'(exp_s)) begin
      miscompares++;
      $display("FAIL perf: got issue=%0d stall=%0d expected %0d %0d", perf_issue, perf_stall, exp_i, exp_s);
    end
    $display("test_perf done");
  endtask

  // Scoreboard: each FU is busy, and is either waiting on a producer set, about to
  // pulse issue, running, or holding a result for the bus.
  task automatic test_random();
    bit       m_busy [3];
    bit       m_wait [3];
    bit       m_iss  [3];
    bit       m_run  [3];
    bit       m_res  [3];
    bit [2:0] m_deps [3];
    bit       snap   [3];
    int       m_rd   [3];
    int       m_rr;
    int       g;
    int       f;
    int       errs;
    bit       exp_ready;
    bit [2:0] exp_busy;
    bit [2:0] exp_iss;
    bit [2:0] d;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 0; m_wait[k] = 0; m_iss[k] = 0; m_run[k] = 0; m_res[k] = 0; m_deps[k] = 0; m_rd[k] = 0;
    end
    m_rr = 0;
    errs = 0;
    for (int c = 0; c < 800; c++) begin
      flush      = ($urandom_range(0, 39) == 0);
      disp_valid = ($urandom_range(0, 9) < 6);
      disp_fu    = 2'($urandom_range(0, 3));
      disp_rd    = 5'($urandom_range(0, 7));
      disp_t1    = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      disp_t2    = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      fu_done    = 3'($urandom_range(0, 7));
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        exp_busy[k] = m_busy[k];
        exp_iss[k]  = m_iss[k];
        snap[k]     = m_busy[k];
      end
      g = -1;
      if (!flush)
        for (int i = 0; i < 3; i++)
          if (g < 0 && m_res[(m_rr + i) % 3]) g = (m_rr + i) % 3;
      f = int'(disp_fu);
      exp_ready = !flush && (f < 3);
      if (exp_ready && m_busy[f]) exp_ready = 0;
      for (int k = 0; k < 3; k++)
        if (disp_rd != 0 && m_busy[k] && m_rd[k] == int'(disp_rd)) exp_ready = 0;
      vectors++;
      if (busy !== exp_busy || fu_issue !== exp_iss || disp_ready !== exp_ready) begin
        miscompares++; errs++;
        if (errs < 10)
          $display("FAIL rand_ctl c=%0d: got busy=%b issue=%b ready=%b expected %b %b %b",
                   c, busy, fu_issue, disp_ready, exp_busy, exp_iss, exp_ready);
      end
      vectors++;
      if (wb_valid !== (g >= 0) || wb_fu !== 2'((g >= 0) ? g : 0) || wb_rd !== 5'((g >= 0) ? m_rd[g] : 0)) begin
        miscompares++; errs++;
        if (errs < 10)
          $display("FAIL rand_wb c=%0d: got v=%b fu=%0d rd=%0d expected grant %0d", c, wb_valid, wb_fu, wb_rd, g);
      end
      if (flush) begin
        for (int k = 0; k < 3; k++) begin
          m_busy[k] = 0; m_wait[k] = 0; m_iss[k] = 0; m_run[k] = 0; m_res[k] = 0; m_deps[k] = 0; m_rd[k] = 0;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (m_res[k]) begin
            if (g == k) begin m_res[k] = 0; m_busy[k] = 0; end
          end else if (m_run[k]) begin
            if (fu_done[k]) begin m_run[k] = 0; m_res[k] = 1; end
          end else if (m_iss[k]) begin
            m_iss[k] = 0; m_run[k] = 1;
          end else if (m_wait[k]) begin
            d = m_deps[k];
            for (int j = 0; j < 3; j++)
              if (d[j] && (!snap[j] || g == j)) d[j] = 0;
            m_deps[k] = d;
            if (d == 0) begin m_wait[k] = 0; m_iss[k] = 1; end
          end
        end
        if (disp_valid && exp_ready) begin
          d = 0;
          if (disp_t1[2] && snap[disp_t1[1:0]] && g != int'(disp_t1[1:0])) d[disp_t1[1:0]] = 1;
          if (disp_t2[2] && snap[disp_t2[1:0]] && g != int'(disp_t2[1:0])) d[disp_t2[1:0]] = 1;
          m_busy[f] = 1; m_rd[f] = int'(disp_rd); m_deps[f] = d;
          if (d == 0) m_iss[f] = 1; else m_wait[f] = 1;
        end
        if (g >= 0) m_rr = (g + 1) % 3;
      end
      step();
    end
    idle_inputs();
    $display("test_random done, %0d mismatching cycles", errs);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RST = 1'b0;
    idle_inputs();
    test_reset();
    test_ready_path();
    test_dependency();
    test_bypass();
    test_arbitration();
    test_hazards();
    test_flush();
    test_rst_mid();
    test_perf();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
